ddsm_ctrl: RTL and testbench

Sequencing controller for the error-feedback-modulator (EFM) chain of the MASH delta-sigma modulator.
- Accepts a fractional word through a valid/ready handshake and drives it into the first EFM stage.
- Runs the start-up sequence: clear, then flush until the pipelined carry chain has settled, then flag the output valid.
- Optionally injects LFSR-based LSB dither as the first stage's quantize carry-in.

---
 rtl/ddsm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ddsm_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ddsm_ctrl.sv
// Sequencing controller for the MASH delta-sigma modulator EFM chain.
// Holds the fractional word, runs the clear/flush start-up sequence and
// sources optional LFSR dither as the first stage's quantize carry-in.
// Every output is decoded from registered state or taken straight from a
// register, so no input reaches an output without passing a flop.
module ddsm_ctrl #(
  parameter int          P_DATA_WIDTH = 6,
  parameter int          P_FLUSH_CYC  = 4,
  parameter logic [14:0] P_LFSR_SEED  = 15'h0001
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cfg_valid,
  input  logic [P_DATA_WIDTH-1:0] i_cfg_frac,
  output logic                    o_cfg_ready,
  input  logic                    i_enable,
  input  logic                    i_dither_en,
  output logic [P_DATA_WIDTH-1:0] o_frac,
  output logic                    o_dither,
  output logic                    o_efm_clr,
  output logic                    o_out_valid,
  output logic                    o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Loaded in CLEAR so FLUSH lasts exactly P_FLUSH_CYC cycles (counts down to 0).
  localparam logic [7:0] FLUSH_LOAD = 8'(P_FLUSH_CYC - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [P_DATA_WIDTH-1:0] frac_r;
  logic [7:0]              flush_cnt_r;
  logic [14:0]             lfsr_r;
  logic                    dither_r;
  logic                    efm_clr_s;
  logic                    busy_s;
  logic                    out_valid_s;
  logic                    cfg_ready_s;
  logic                    run_s;

  // State register; async reset returns the sequencer to IDLE at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a low enable aborts to IDLE ahead of any other move.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) state_nxt_s = ST_CLEAR;
        else          state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (!i_enable) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!i_enable)                state_nxt_s = ST_IDLE;
        else if (flush_cnt_r == 8'd0) state_nxt_s = ST_RUN;
        else                          state_nxt_s = ST_FLUSH;
      end
      ST_RUN: begin
        if (!i_enable) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    efm_clr_s   = 1'b1;
    busy_s      = 1'b0;
    out_valid_s = 1'b0;
    cfg_ready_s = 1'b1;
    run_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        efm_clr_s = 1'b1;
      end
      ST_CLEAR: begin
        busy_s      = 1'b1;
        cfg_ready_s = 1'b0;
      end
      ST_FLUSH: begin
        efm_clr_s   = 1'b0;
        busy_s      = 1'b1;
        cfg_ready_s = 1'b0;
      end
      ST_RUN: begin
        efm_clr_s   = 1'b0;
        out_valid_s = 1'b1;
        run_s       = 1'b1;
      end
      default: begin
        efm_clr_s = 1'b1;
      end
    endcase
  end

  // Flush counter: loaded in CLEAR, counts down while flushing the carry pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_cnt_r <= 8'd0;
    end else if (state_r == ST_CLEAR) begin
      flush_cnt_r <= FLUSH_LOAD;
    end else if ((state_r == ST_FLUSH) && (flush_cnt_r != 8'd0)) begin
      flush_cnt_r <= flush_cnt_r - 8'd1;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Fractional word capture on a valid/ready transfer; RUN writes retune live.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frac_r <= '0;
    end else if (i_cfg_valid && cfg_ready_s) begin
      frac_r <= i_cfg_frac;
    end else begin
      frac_r <= frac_r;
    end
  end

  // Dither LFSR: reseeded on entry to CLEAR, steps only while dithering in RUN.
  // Shifts toward the LSB with feedback from the two top bits into bit 14.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_r <= P_LFSR_SEED;
    end else if ((state_r == ST_IDLE) && i_enable) begin
      lfsr_r <= P_LFSR_SEED;
    end else if (run_s && i_dither_en) begin
      lfsr_r <= {lfsr_r[14] ^ lfsr_r[13], lfsr_r[14:1]};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Registered dither bit; the enable acts on the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dither_r <= 1'b0;
    end else begin
      dither_r <= run_s & i_dither_en & lfsr_r[0];
    end
  end

  assign o_frac      = frac_r;
  assign o_dither    = dither_r & run_s;
  assign o_efm_clr   = efm_clr_s;
  assign o_out_valid = out_valid_s;
  assign o_busy      = busy_s;
  assign o_cfg_ready = cfg_ready_s;

endmodule

// File: tb/tb_ddsm_ctrl.sv
// Self-checking bench for ddsm_ctrl: start-up timing, config handshake,
// abort, dither sequence against an arithmetic LFSR model, async reset.
// A second instance with a richer seed exercises the LFSR beyond seed 1.
module tb_ddsm_ctrl;
  localparam int          W     = 6;
  localparam int          F     = 4;
  localparam logic [14:0] SEED  = 15'h0001;
  localparam logic [14:0] SEED2 = 15'h5A3C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_frac = '0;
  logic         enable = 1'b0;
  logic         dither_en = 1'b0;
  logic         cfg_ready, dither, efm_clr, out_valid, busy;
  logic [W-1:0] frac;
  logic         cfg_ready2, dither2, efm_clr2, out_valid2, busy2;
  logic [W-1:0] frac2;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_frac = '0;

  ddsm_ctrl #(.P_DATA_WIDTH(W), .P_FLUSH_CYC(F), .P_LFSR_SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .i_cfg_frac(cfg_frac),
    .o_cfg_ready(cfg_ready), .i_enable(enable), .i_dither_en(dither_en),
    .o_frac(frac), .o_dither(dither), .o_efm_clr(efm_clr),
    .o_out_valid(out_valid), .o_busy(busy));

  ddsm_ctrl #(.P_DATA_WIDTH(W), .P_FLUSH_CYC(F), .P_LFSR_SEED(SEED2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .i_cfg_frac(cfg_frac),
    .o_cfg_ready(cfg_ready2), .i_enable(enable), .i_dither_en(dither_en),
    .o_frac(frac2), .o_dither(dither2), .o_efm_clr(efm_clr2),
    .o_out_valid(out_valid2), .o_busy(busy2));

  always #5 clk = ~clk;

  // Spec LFSR step as plain arithmetic: shift right, feedback = bit14 ^ bit13 into bit 14.
  function automatic int lfsr_next(input int m);
    int fb;
    fb = ((m >> 14) ^ (m >> 13)) & 1;
    return ((m >> 1) | (fb << 14)) & 32'h7FFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (efm_clr !== 1'b1)  begin errors++; $display("FAIL reset_clr got %b exp 1", efm_clr); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frac !== '0)       begin errors++; $display("FAIL reset_frac got %0d exp 0", frac); end
    checks++; if (dither !== 1'b0)   begin errors++; $display("FAIL reset_dither got %b exp 0", dither); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_frac = '0;
    tick();
  endtask

  // From IDLE: enable (optionally with a same-edge config write) and check
  // the cycle-by-cycle phase: n=1 CLEAR, 2..F+1 FLUSH, >=F+2 RUN.
  task automatic test_startup(input logic [W-1:0] v, input logic use_cfg);
    enable = 1'b1;
    cfg_valid = use_cfg;
    cfg_frac = v;
    for (int n = 1; n <= F + 3; n++) begin
      tick();
      if (n == 1) begin
        cfg_valid = 1'b0;
        if (use_cfg) exp_frac = v;
      end
      checks++; if (efm_clr !== (n == 1)) begin errors++; $display("FAIL start_clr n=%0d got %b exp %b", n, efm_clr, (n == 1)); end
      checks++; if (busy !== (n <= F + 1)) begin errors++; $display("FAIL start_busy n=%0d got %b exp %b", n, busy, (n <= F + 1)); end
      checks++; if (out_valid !== (n >= F + 2)) begin errors++; $display("FAIL start_valid n=%0d got %b exp %b", n, out_valid, (n >= F + 2)); end
      checks++; if (cfg_ready !== !(n <= F + 1)) begin errors++; $display("FAIL start_ready n=%0d got %b exp %b", n, cfg_ready, !(n <= F + 1)); end
      checks++; if (frac !== exp_frac) begin errors++; $display("FAIL start_frac n=%0d got %0d exp %0d", n, frac, exp_frac); end
    end
  endtask

  // In RUN: retune with 37, zero and random words; output stays valid, no clear.
  task automatic test_retune();
    logic [W-1:0] v;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      v = 6'd37;
      else if (i == 1) v = 6'd0;
      else             v = W'($urandom_range(0, 63));
      cfg_valid = 1'b1;
      cfg_frac = v;
      tick();
      cfg_valid = 1'b0;
      exp_frac = v;
      checks++; if (frac !== v) begin errors++; $display("FAIL retune_frac got %0d exp %0d", frac, v); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL retune_valid got %b exp 1", out_valid); end
      checks++; if (efm_clr !== 1'b0) begin errors++; $display("FAIL retune_clr got %b exp 0", efm_clr); end
    end
  endtask

  // A write offered during CLEAR/FLUSH is not taken until RUN makes ready high.
  task automatic test_hold();
    logic [W-1:0] v;
    v = exp_frac ^ 6'd42;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    cfg_valid = 1'b1;
    cfg_frac = v;
    for (int n = 2; n <= F + 2; n++) begin
      tick();
      checks++; if (frac !== exp_frac) begin errors++; $display("FAIL hold_frac n=%0d got %0d exp %0d", n, frac, exp_frac); end
      checks++; if (cfg_ready !== (n == F + 2)) begin errors++; $display("FAIL hold_ready n=%0d got %b exp %b", n, cfg_ready, (n == F + 2)); end
    end
    tick();
    cfg_valid = 1'b0;
    exp_frac = v;
    checks++; if (frac !== v) begin errors++; $display("FAIL hold_take got %0d exp %0d", frac, v); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", out_valid); end
  endtask

  // Abort in FLUSH cycle 2, then a full re-start.
  task automatic test_abort();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_pre_valid n=%0d got %b exp 0", n, out_valid); end
    end
    enable = 1'b0;
    tick();
    checks++; if (efm_clr !== 1'b1) begin errors++; $display("FAIL abort_clr got %b exp 1", efm_clr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", cfg_ready); end
    test_startup(6'd0, 1'b0);
  endtask

  // Start from IDLE with dither on, reach the first RUN cycle, and
  // compare n_run cycles of o_dither against the model for both seeds.
  task automatic run_dither(input int n_run, input logic rand_en);
    int m1, m2;
    logic en, e1, e2;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    dither_en = 1'b1;
    for (int n = 1; n <= F + 2; n++) begin
      tick();
      checks++; if (dither !== 1'b0 || dither2 !== 1'b0) begin errors++; $display("FAIL dither_startup n=%0d got %b%b exp 00", n, dither, dither2); end
    end
    m1 = int'(SEED);
    m2 = int'(SEED2);
    for (int i = 0; i < n_run; i++) begin
      if (rand_en && i >= 110)          en = 1'($urandom_range(0, 1));
      else if (i >= 100 && i < 110)     en = 1'b0;
      else                              en = 1'b1;
      dither_en = en;
      tick();
      e1 = en ? 1'(m1 & 1) : 1'b0;
      e2 = en ? 1'(m2 & 1) : 1'b0;
      if (en) begin
        m1 = lfsr_next(m1);
        m2 = lfsr_next(m2);
      end
      checks++; if (dither !== e1) begin errors++; $display("FAIL dither_seed1 i=%0d got %b exp %b", i, dither, e1); end
      checks++; if (dither2 !== e2) begin errors++; $display("FAIL dither_seed2 i=%0d got %b exp %b", i, dither2, e2); end
    end
  endtask

  task automatic test_dither();
    run_dither(150, 1'b1);
    run_dither(25, 1'b0);
    dither_en = 1'b0;
    tick();
    checks++; if (dither !== 1'b0 || dither2 !== 1'b0) begin errors++; $display("FAIL dither_off got %b%b exp 00", dither, dither2); end
  endtask

  // Reset asserted between edges in RUN must act without a clock.
  task automatic test_async_reset();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", out_valid); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (efm_clr !== 1'b1)  begin errors++; $display("FAIL areset_clr got %b exp 1", efm_clr); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b exp 1", cfg_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (frac !== '0)       begin errors++; $display("FAIL areset_frac got %0d exp 0", frac); end
    checks++; if (dither !== 1'b0)   begin errors++; $display("FAIL areset_dither got %b exp 0", dither); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_frac = '0;
    tick();
    checks++; if (efm_clr !== 1'b1) begin errors++; $display("FAIL areset_idle_clr got %b exp 1", efm_clr); end
  endtask

  initial begin
    test_reset();
    test_startup(6'd21, 1'b1);
    test_retune();
    test_hold();
    test_abort();
    test_dither();
    enable = 1'b0;
    tick();
    test_startup(6'd45, 1'b1);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
